idu_pipe: RTL and testbench

Registered, handshaked instruction decode stage that succeeds the combinational decoder. It decodes the full RV32I base set, or RV32E when parameterised. Decoded bundles are buffered in a parametrised FIFO between IFU and EXU so the fetch side can run ahead of a stalled execute stage. Illegal encodings are flagged and passed downstream, not silently mapped to a no-op. A flush input discards everything in flight on redirect.

---
 rtl/idu_pipe_if.sv | 36 +++
 rtl/idu_pipe.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_idu_pipe.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/idu_pipe_if.sv
// Handshake bundles around the decode stage: fetch side (IFU -> IDU) and
// decoded-bundle side (IDU -> EXU).

interface idu_fetch_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;

  modport master (output in_valid, in_inst, in_pc, input in_ready);
  modport slave  (input in_valid, in_inst, in_pc, output in_ready);
endinterface

interface idu_dec_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [2:0]  out_func3;
  logic [4:0]  out_alu_op;
  logic [31:0] out_imm;
  logic        out_illegal;

  modport master (
    output out_valid, out_pc, out_rs1, out_rs2, out_rd, out_func3,
           out_alu_op, out_imm, out_illegal,
    input  out_ready
  );
  modport slave (
    input  out_valid, out_pc, out_rs1, out_rs2, out_rd, out_func3,
           out_alu_op, out_imm, out_illegal,
    output out_ready
  );
endinterface

// File: rtl/idu_pipe.sv
// Registered RV32I/RV32E decode stage: combinational decode of the fetched word
// feeding a DEPTH-entry FIFO of decoded bundles towards the execute stage.

module idu_pipe #(
  parameter int DEPTH     = 2,
  parameter bit RV32E     = 1'b0,
  parameter bit EN_SYSTEM = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  idu_fetch_if.slave             fetch,
  idu_dec_if.master              dec,
  output logic [$clog2(DEPTH):0] out_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int MEM_N = 2 ** PTR_W;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0]  F7_BASE = 7'b0000000;
  localparam logic [6:0]  F7_ALT  = 7'b0100000;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [4:0] {
    ALU_ADD     = 5'd0,
    ALU_SUB     = 5'd1,
    ALU_SLL     = 5'd2,
    ALU_SLT     = 5'd3,
    ALU_SLTU    = 5'd4,
    ALU_XOR     = 5'd5,
    ALU_SRL     = 5'd6,
    ALU_SRA     = 5'd7,
    ALU_OR      = 5'd8,
    ALU_AND     = 5'd9,
    ALU_LUI     = 5'd10,
    ALU_AUIPC   = 5'd11,
    ALU_JAL     = 5'd12,
    ALU_JALR    = 5'd13,
    ALU_BRANCH  = 5'd14,
    ALU_LOAD    = 5'd15,
    ALU_STORE   = 5'd16,
    ALU_SYSTEM  = 5'd17,
    ALU_FENCE   = 5'd18,
    ALU_ILLEGAL = 5'd31
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  func3;
    alu_op_e     alu_op;
    logic [31:0] imm;
    logic        illegal;
  } entry_t;

  // Shared func3 -> ALU op map for OP and OP-IMM; alt selects SUB/SRA.
  function automatic alu_op_e base_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  rd_f;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign inst   = fetch.in_inst;
  assign opcode = inst[6:0];
  assign f7     = inst[31:25];
  assign f3     = inst[14:12];
  assign rd_f   = inst[11:7];
  assign rs1_f  = inst[19:15];
  assign rs2_f  = inst[24:20];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'h000};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  alu_op_e     op;
  logic [31:0] imm;
  logic        legal;
  logic        use_rd;
  logic        use_rs1;
  logic        use_rs2;
  logic        no_rd;
  entry_t      dec_entry;

  // NOTE: every signal written in this block gets a default first, so no
  // path through the case statements can leave a latch behind.
  always_comb begin
    op      = ALU_ADD;
    imm     = '0;
    legal   = 1'b1;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    no_rd   = 1'b0;

    case (opcode)
      OPC_LUI: begin
        op = ALU_LUI;   imm = imm_u; use_rd = 1'b1;
      end
      OPC_AUIPC: begin
        op = ALU_AUIPC; imm = imm_u; use_rd = 1'b1;
      end
      OPC_JAL: begin
        op = ALU_JAL;   imm = imm_j; use_rd = 1'b1;
      end
      OPC_JALR: begin
        op = ALU_JALR;  imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
        legal = (f3 == 3'b000);
      end
      OPC_BRANCH: begin
        op = ALU_BRANCH; imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; no_rd = 1'b1;
        legal = (f3 != 3'b010) && (f3 != 3'b011);
      end
      OPC_LOAD: begin
        op = ALU_LOAD;  imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      OPC_STORE: begin
        op = ALU_STORE; imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1; no_rd = 1'b1;
        legal = (f3 < 3'b011);
      end
      OPC_OP_IMM: begin
        op      = base_op(f3, (f3 == 3'b101) && (f7 == F7_ALT));
        imm     = imm_i;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        // Shift-immediates carry func7 in the upper immediate bits.
        if (f3 == 3'b001)      legal = (f7 == F7_BASE);
        else if (f3 == 3'b101) legal = (f7 == F7_BASE) || (f7 == F7_ALT);
      end
      OPC_OP: begin
        op      = base_op(f3, f7 == F7_ALT);
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        legal   = (f7 == F7_BASE) ||
                  ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_FENCE: begin
        op = ALU_FENCE; imm = imm_i;
        legal = (f3 == 3'b000);
      end
      OPC_SYSTEM: begin
        op  = ALU_SYSTEM;
        imm = imm_i;
        if (!EN_SYSTEM) begin
          legal = 1'b0;
        end else if (f3 == 3'b000) begin
          legal = (inst == INST_ECALL) || (inst == INST_EBREAK);
        end else begin
          // CSR*I forms reuse the rs1 field as a 5-bit immediate.
          legal   = (f3 != 3'b100);
          use_rd  = 1'b1;
          use_rs1 = ~f3[2];
        end
      end
      default: legal = 1'b0;
    endcase

    if (RV32E && ((use_rd && rd_f[4]) || (use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4])))
      legal = 1'b0;

    dec_entry         = '0;
    dec_entry.pc      = fetch.in_pc;
    dec_entry.rs1     = rs1_f;
    dec_entry.rs2     = rs2_f;
    dec_entry.rd      = (no_rd && legal) ? 5'd0 : rd_f;
    dec_entry.func3   = f3;
    dec_entry.alu_op  = legal ? op : ALU_ILLEGAL;
    dec_entry.imm     = legal ? imm : 32'h0;
    dec_entry.illegal = ~legal;
  end

  // ---------------------------------------------------------------------------
  // Decoded-bundle FIFO
  // ---------------------------------------------------------------------------
  entry_t           mem [MEM_N];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             not_full;
  logic             not_empty;
  logic             push;
  logic             pop;
  entry_t           out_entry;

  assign not_full  = (count_q < DEPTH_C);
  assign not_empty = (count_q != '0);
  assign push      = fetch.in_valid & not_full & ~flush;
  assign pop       = not_empty & dec.out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; occupancy gates every
  // read, so stale contents are never observable and the array maps to RAM.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= dec_entry;
  end

  // Empty (including during reset) presents an all-zero bundle.
  assign out_entry = not_empty ? mem[rd_ptr_q] : '0;

  assign fetch.in_ready  = not_full;
  assign dec.out_valid   = not_empty;
  assign dec.out_pc      = out_entry.pc;
  assign dec.out_rs1     = out_entry.rs1;
  assign dec.out_rs2     = out_entry.rs2;
  assign dec.out_rd      = out_entry.rd;
  assign dec.out_func3   = out_entry.func3;
  assign dec.out_alu_op  = out_entry.alu_op;
  assign dec.out_imm     = out_entry.imm;
  assign dec.out_illegal = out_entry.illegal;
  assign out_count       = count_q;

endmodule

// File: tb/tb_idu_pipe.sv
// Directed bench for idu_pipe: a decode vector table on a default RV32I instance
// and a DEPTH=1 RV32E/no-SYSTEM instance, plus flow-control, flush and reset sequences.

module tb_idu_pipe;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush;
  logic       flush_e;
  logic [1:0] cnt;
  logic [0:0] cnt_e;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  idu_fetch_if f  ();
  idu_dec_if   d  ();
  idu_fetch_if fe ();
  idu_dec_if   de ();

  idu_pipe #(.DEPTH(2), .RV32E(1'b0), .EN_SYSTEM(1'b1)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .fetch(f), .dec(d), .out_count(cnt)
  );

  idu_pipe #(.DEPTH(1), .RV32E(1'b1), .EN_SYSTEM(1'b0)) dut_e (
    .clock(clock), .reset(reset), .flush(flush_e),
    .fetch(fe), .dec(de), .out_count(cnt_e)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    int          tgt;   // 0 = RV32I DEPTH=2 instance, 1 = RV32E DEPTH=1 instance
    logic [31:0] inst;
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs [$];

  // Push one word into the selected instance with out_ready=1, check the
  // bundle one cycle later, then check it drains on the following edge.
  task automatic apply_vec(input vec_t v, input logic [31:0] pc);
    logic        ov, oill;
    logic [31:0] opc, oimm;
    logic [4:0]  ors1, ors2, ord, oop;
    logic [2:0]  of3;
    if (v.tgt == 0) begin
      f.in_valid = 1'b1; f.in_inst = v.inst; f.in_pc = pc;
    end else begin
      fe.in_valid = 1'b1; fe.in_inst = v.inst; fe.in_pc = pc;
    end
    @(negedge clock);
    f.in_valid  = 1'b0;
    fe.in_valid = 1'b0;
    if (v.tgt == 0) begin
      ov = d.out_valid; opc = d.out_pc; ors1 = d.out_rs1; ors2 = d.out_rs2; ord = d.out_rd;
      of3 = d.out_func3; oop = d.out_alu_op; oimm = d.out_imm; oill = d.out_illegal;
    end else begin
      ov = de.out_valid; opc = de.out_pc; ors1 = de.out_rs1; ors2 = de.out_rs2; ord = de.out_rd;
      of3 = de.out_func3; oop = de.out_alu_op; oimm = de.out_imm; oill = de.out_illegal;
    end
    check($sformatf("vec %08h valid", v.inst), {31'd0, ov}, 32'd1);
    check($sformatf("vec %08h pc", v.inst), opc, pc);
    check($sformatf("vec %08h alu_op", v.inst), {27'd0, oop}, {27'd0, v.op});
    check($sformatf("vec %08h rd", v.inst), {27'd0, ord}, {27'd0, v.rd});
    check($sformatf("vec %08h rs1", v.inst), {27'd0, ors1}, {27'd0, v.inst[19:15]});
    check($sformatf("vec %08h rs2", v.inst), {27'd0, ors2}, {27'd0, v.inst[24:20]});
    check($sformatf("vec %08h func3", v.inst), {29'd0, of3}, {29'd0, v.inst[14:12]});
    check($sformatf("vec %08h imm", v.inst), oimm, v.imm);
    check($sformatf("vec %08h illegal", v.inst), {31'd0, oill}, {31'd0, v.ill});
    @(negedge clock);
    ov = (v.tgt == 0) ? d.out_valid : de.out_valid;
    check($sformatf("vec %08h drained", v.inst), {31'd0, ov}, 32'd0);
  endtask

  logic [31:0] seq_inst [3] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
  logic [31:0] seq_pc   [3] = '{32'h0000_0200, 32'h0000_0204, 32'h0000_0208};
  logic [31:0] popped [$];

  initial begin
    int idx;

    reset = 1'b1; flush = 1'b0; flush_e = 1'b0;
    f.in_valid  = 1'b0; f.in_inst  = '0; f.in_pc  = '0; d.out_ready  = 1'b1;
    fe.in_valid = 1'b0; fe.in_inst = '0; fe.in_pc = '0; de.out_ready = 1'b1;

    //          tgt  inst           op  rd  imm            ill
    vecs.push_back('{0, 32'h0050_0093,  0,  1, 32'h0000_0005, 0}); // addi x1,x0,5
    vecs.push_back('{0, 32'h4020_8133,  1,  2, 32'h0000_0000, 0}); // sub
    vecs.push_back('{0, 32'h0020_9463, 14,  0, 32'h0000_0008, 0}); // bne +8
    vecs.push_back('{0, 32'hff01_0113,  0,  2, 32'hFFFF_FFF0, 0}); // addi sp,sp,-16
    vecs.push_back('{0, 32'h0000_A003, 15,  0, 32'h0000_0000, 0}); // lw
    vecs.push_back('{0, 32'h0000_B003, 31,  0, 32'h0000_0000, 1}); // load func3=011
    vecs.push_back('{0, 32'h0200_0033, 31,  0, 32'h0000_0000, 1}); // OP func7=0000001
    vecs.push_back('{0, 32'h1234_50B7, 10,  1, 32'h1234_5000, 0}); // lui
    vecs.push_back('{0, 32'h0000_1197, 11,  3, 32'h0000_1000, 0}); // auipc
    vecs.push_back('{0, 32'hFFDF_F06F, 12,  0, 32'hFFFF_FFFC, 0}); // jal -4
    vecs.push_back('{0, 32'h0020_A623, 16,  0, 32'h0000_000C, 0}); // sw 12(x1)
    vecs.push_back('{0, 32'h0001_10E7, 31,  1, 32'h0000_0000, 1}); // jalr func3=001
    vecs.push_back('{0, 32'h0030_9093,  2,  1, 32'h0000_0003, 0}); // slli 3
    vecs.push_back('{0, 32'h0230_9093, 31,  1, 32'h0000_0000, 1}); // slli bad func7
    vecs.push_back('{0, 32'h0010_0073, 17,  0, 32'h0000_0001, 0}); // ebreak
    vecs.push_back('{0, 32'h3001_10F3, 17,  1, 32'h0000_0300, 0}); // csrrw
    vecs.push_back('{0, 32'h0020_E7B3,  8, 15, 32'h0000_0000, 0}); // or
    vecs.push_back('{0, 32'h4020_D7B3,  7, 15, 32'h0000_0000, 0}); // sra
    vecs.push_back('{0, 32'h4020_C7B3, 31, 15, 32'h0000_0000, 1}); // xor func7=0100000
    vecs.push_back('{0, 32'h0000_0000, 31,  0, 32'h0000_0000, 1}); // all-zero word
    vecs.push_back('{1, 32'h0020_8833, 31, 16, 32'h0000_0000, 1}); // RV32E add x16
    vecs.push_back('{1, 32'h0010_0073, 31,  0, 32'h0000_0000, 1}); // SYSTEM disabled
    vecs.push_back('{1, 32'h0020_87B3,  0, 15, 32'h0000_0000, 0}); // RV32E add x15
    vecs.push_back('{1, 32'h0050_0093,  0,  1, 32'h0000_0005, 0}); // addi x1,x0,5

    // Reset state, checked while reset is held and after release.
    #12;
    check("reset out_valid", {31'd0, d.out_valid}, 32'd0);
    check("reset count", {30'd0, cnt}, 32'd0);
    check("reset out_pc", d.out_pc, 32'd0);
    check("reset alu_op", {27'd0, d.out_alu_op}, 32'd0);
    check("reset illegal", {31'd0, d.out_illegal}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post-reset in_ready", {31'd0, f.in_ready}, 32'd1);
    check("post-reset in_ready e", {31'd0, fe.in_ready}, 32'd1);

    foreach (vecs[i]) apply_vec(vecs[i], 32'h0000_1000 + 32'(i * 4));

    // Backpressure: stall three pushes into a DEPTH=2 FIFO, then drain.
    idx = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      d.out_ready = (cyc >= 5);
      f.in_valid  = (idx < 3);
      f.in_inst   = (idx < 3) ? seq_inst[idx] : 32'h0;
      f.in_pc     = (idx < 3) ? seq_pc[idx] : 32'h0;
      #1;
      if (cyc == 3 || cyc == 4) begin
        check("stall out_pc", d.out_pc, seq_pc[0]);
        check("stall rd", {27'd0, d.out_rd}, 32'd1);
        check("stall in_ready", {31'd0, f.in_ready}, 32'd0);
        check("stall count", {30'd0, cnt}, 32'd2);
      end
      if (cyc == 7) begin
        check("push+pop count", {30'd0, cnt}, 32'd1);
        check("push+pop head", d.out_pc, seq_pc[2]);
      end
      if (d.out_valid && d.out_ready) popped.push_back(d.out_pc);
      if (f.in_valid && f.in_ready) idx++;
      @(negedge clock);
      if (idx == 3 && popped.size() == 3) break;
    end
    f.in_valid = 1'b0;
    check("drain pops", popped.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      check("drain order", (i < popped.size()) ? popped[i] : 32'hDEAD_DEAD, seq_pc[i]);
    check("drain count", {30'd0, cnt}, 32'd0);
    check("drain out_valid", {31'd0, d.out_valid}, 32'd0);

    // Flush with one entry held, while a push and a pop are both offered.
    d.out_ready = 1'b0;
    f.in_valid = 1'b1; f.in_inst = 32'h0050_0093; f.in_pc = 32'h300;
    @(negedge clock);
    check("pre-flush count", {30'd0, cnt}, 32'd1);
    flush = 1'b1; d.out_ready = 1'b1; f.in_inst = 32'h0060_0093; f.in_pc = 32'h304;
    @(negedge clock);
    flush = 1'b0; f.in_valid = 1'b0;
    check("flush count", {30'd0, cnt}, 32'd0);
    check("flush out_valid", {31'd0, d.out_valid}, 32'd0);
    check("flush in_ready", {31'd0, f.in_ready}, 32'd1);
    check("flush out_pc", d.out_pc, 32'd0);
    @(negedge clock);
    check("flush push dropped", {30'd0, cnt}, 32'd0);

    // Flush a full FIFO together with in_valid.
    d.out_ready = 1'b0;
    f.in_valid = 1'b1; f.in_inst = 32'h0050_0093; f.in_pc = 32'h400;
    @(negedge clock);
    f.in_pc = 32'h404;
    @(negedge clock);
    check("fill count", {30'd0, cnt}, 32'd2);
    flush = 1'b1; f.in_pc = 32'h408;
    @(negedge clock);
    flush = 1'b0; f.in_valid = 1'b0;
    check("full flush count", {30'd0, cnt}, 32'd0);
    check("full flush out_valid", {31'd0, d.out_valid}, 32'd0);

    // Asynchronous reset mid-stream, away from any clock edge.
    f.in_valid = 1'b1; f.in_inst = 32'h1234_50B7; f.in_pc = 32'h500;
    @(negedge clock);
    f.in_pc = 32'h504;
    @(negedge clock);
    f.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async reset out_valid", {31'd0, d.out_valid}, 32'd0);
    check("async reset count", {30'd0, cnt}, 32'd0);
    check("async reset out_pc", d.out_pc, 32'd0);
    check("async reset imm", d.out_imm, 32'd0);
    #3 reset = 1'b0;
    @(negedge clock);
    check("after reset in_ready", {31'd0, f.in_ready}, 32'd1);
    d.out_ready = 1'b1;
    f.in_valid = 1'b1; f.in_inst = 32'h0000_1197; f.in_pc = 32'h600;
    @(negedge clock);
    f.in_valid = 1'b0;
    check("after reset head pc", d.out_pc, 32'h600);
    check("after reset head op", {27'd0, d.out_alu_op}, 32'd11);

    // DEPTH=1 instance: one entry fills it.
    de.out_ready = 1'b0;
    fe.in_valid = 1'b1; fe.in_inst = 32'h0050_0093; fe.in_pc = 32'h700;
    @(negedge clock);
    fe.in_inst = 32'h0060_0093; fe.in_pc = 32'h704;
    check("depth1 count", {31'd0, cnt_e}, 32'd1);
    check("depth1 in_ready", {31'd0, fe.in_ready}, 32'd0);
    @(negedge clock);
    fe.in_valid = 1'b0;
    check("depth1 full holds head", de.out_pc, 32'h700);
    de.out_ready = 1'b1;
    @(negedge clock);
    check("depth1 drained", {31'd0, cnt_e}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
